// File: rtl/fp8_pkg.sv
// FP8 E4M3 format constants, the unpacked-operand record and the unpack helper
// shared by the adder datapath.
package fp8_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;

  // Significand including the hidden bit, and the aligned width (significand
  // plus guard, round and sticky positions).
  localparam int SIG_W = MAN_W + 1;
  localparam int ALN_W = SIG_W + 3;

  // Largest exponent field value; an exponent beyond this after rounding is an
  // overflow, as is exactly this exponent with an all-ones mantissa (NaN code).
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [7:0] FP8_NAN     = 8'h7F;
  localparam logic [7:0] FP8_MAXNORM = 8'h7E;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;     // effective exponent: subnormals report 1
    logic [SIG_W-1:0] sig;     // {hidden, mantissa}
    logic             is_nan;
    logic             is_zero;
  } fp8_unpacked_t;

  // Split an encoding into sign, effective exponent and significand. A zero
  // exponent field is a subnormal: hidden bit 0 and the same scale as exp 1.
  function automatic fp8_unpacked_t fp8_unpack(input logic [7:0] x);
    fp8_unpacked_t u;
    u.sign    = x[7];
    u.is_nan  = (x[6:0] == 7'h7F);
    u.is_zero = (x[6:0] == 7'h00);
    if (x[6:3] == 4'd0) begin
      u.exp = 4'd1;
      u.sig = {1'b0, x[2:0]};
    end else begin
      u.exp = x[6:3];
      u.sig = {1'b1, x[2:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp8_lzc.sv
// Leading-zero counter for the normalization path of the FP8 adder.
// An all-zero input reports W.
module fp8_lzc #(
  parameter int W  = 7,
  parameter int CW = 3
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Scan from LSB upward; the last set bit seen is the most significant one.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        count_o = CW'(W - 1 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/float_adder_e4m3.sv
// FP8 E4M3 (OCP) adder, two-stage pipeline, round-to-nearest-even.
// Stage 1: unpack, magnitude compare, align with sticky, add/subtract.
// Stage 2: normalize (carry or cancellation), round, pack, overflow/NaN/zero.
// Optional macro FP8_SATURATE_EN: overflow clamps to +/-448 instead of NaN.
module float_adder_e4m3
  import fp8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  output logic [7:0] y
);

  localparam logic [EXP_W:0] EXP_TOP = (EXP_W + 1)'(EXP_MAX);

  // ---------------------------------------------------------------- stage 1
  fp8_unpacked_t    ua_s, ub_s;
  logic             a_big_s;
  logic             big_sign_s;
  logic [EXP_W-1:0] big_exp_s, sml_exp_s, exp_diff_s;
  logic [SIG_W-1:0] big_sig_s, sml_sig_s;
  logic [5:0]       sml_pre_s, sml_shf_s;
  logic             sml_sticky_s;
  logic [ALN_W-1:0] big_aln_s, sml_aln_s;
  logic             eff_sub_s;

  logic             s1_valid_d, s1_valid_q;
  logic             s1_nan_d, s1_nan_q;
  logic             s1_neg_zero_d, s1_neg_zero_q;
  logic             s1_sign_d, s1_sign_q;
  logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
  logic [ALN_W:0]   s1_sum_d, s1_sum_q;

  // Order operands by magnitude, align the smaller one and add or subtract.
  always_comb begin
    ua_s    = fp8_unpack(a);
    ub_s    = fp8_unpack(b);
    // Encodings without the sign bit are monotonic in magnitude.
    a_big_s = (a[6:0] >= b[6:0]);
    if (a_big_s) begin
      big_sign_s = ua_s.sign;
      big_exp_s  = ua_s.exp;
      big_sig_s  = ua_s.sig;
      sml_exp_s  = ub_s.exp;
      sml_sig_s  = ub_s.sig;
    end else begin
      big_sign_s = ub_s.sign;
      big_exp_s  = ub_s.exp;
      big_sig_s  = ub_s.sig;
      sml_exp_s  = ua_s.exp;
      sml_sig_s  = ua_s.sig;
    end
    exp_diff_s = big_exp_s - sml_exp_s;
    sml_pre_s  = {sml_sig_s, 2'b00};
    // Beyond 5 positions the whole significand is past the round bit.
    if (exp_diff_s > 4'd5) begin
      sml_shf_s    = 6'd0;
      sml_sticky_s = |sml_sig_s;
    end else begin
      sml_shf_s    = sml_pre_s >> exp_diff_s;
      sml_sticky_s = |(sml_pre_s & ~(6'b111111 << exp_diff_s));
    end
    big_aln_s = {big_sig_s, 3'b000};
    sml_aln_s = {sml_shf_s, sml_sticky_s};
    eff_sub_s = ua_s.sign ^ ub_s.sign;
    if (eff_sub_s) begin
      s1_sum_d = {1'b0, big_aln_s} - {1'b0, sml_aln_s};
    end else begin
      s1_sum_d = {1'b0, big_aln_s} + {1'b0, sml_aln_s};
    end
    s1_valid_d    = in_valid;
    s1_nan_d      = ua_s.is_nan | ub_s.is_nan;
    // Only (-0)+(-0) yields a negative zero; every other exact zero is +0.
    s1_neg_zero_d = ua_s.is_zero & ub_s.is_zero & ua_s.sign & ub_s.sign;
    s1_sign_d     = big_sign_s;
    s1_exp_d      = big_exp_s;
  end

  // Stage-1 pipeline register; data only loads for accepted pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_nan_q      <= 1'b0;
      s1_neg_zero_q <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_sum_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_valid) begin
        s1_nan_q      <= s1_nan_d;
        s1_neg_zero_q <= s1_neg_zero_d;
        s1_sign_q     <= s1_sign_d;
        s1_exp_q      <= s1_exp_d;
        s1_sum_q      <= s1_sum_d;
      end else begin
        s1_nan_q      <= s1_nan_q;
        s1_neg_zero_q <= s1_neg_zero_q;
        s1_sign_q     <= s1_sign_q;
        s1_exp_q      <= s1_exp_q;
        s1_sum_q      <= s1_sum_q;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [2:0]       lz_s, shift_s;
  logic [EXP_W-1:0] max_shift_s;
  logic [ALN_W-1:0] norm_s;
  logic [EXP_W:0]   exp_n_s, exp_out_s;
  logic             rnd_up_s;
  logic [SIG_W:0]   rnd_s;
  logic [MAN_W-1:0] man_out_s;
  logic             ovf_s;
  logic [7:0]       y_d;

  logic             out_valid_q;
  logic [7:0]       y_q;

  fp8_lzc #(
    .W  (ALN_W),
    .CW (3)
  ) u_lzc (
    .data_i  (s1_sum_q[ALN_W-1:0]),
    .count_o (lz_s)
  );

  // Normalize, round to nearest-even, then pack with special-case priority.
  always_comb begin
    max_shift_s = s1_exp_q - 4'd1;
    shift_s     = 3'd0;
    if (s1_sum_q[ALN_W]) begin
      // Carry out: shift right once, folding the dropped bit into sticky.
      norm_s  = {s1_sum_q[ALN_W:2], |s1_sum_q[1:0]};
      exp_n_s = {1'b0, s1_exp_q} + 5'd1;
    end else begin
      // Cancellation: shift left, but never below exponent 1 (subnormal).
      if ({1'b0, lz_s} < max_shift_s) begin
        shift_s = lz_s;
      end else begin
        shift_s = max_shift_s[2:0];
      end
      norm_s  = s1_sum_q[ALN_W-1:0] << shift_s;
      exp_n_s = {1'b0, s1_exp_q} - {2'b00, shift_s};
    end
    // Round up when guard is set and round/sticky/lsb break the tie upward.
    rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s    = {1'b0, norm_s[6:3]} + {4'b0000, rnd_up_s};
    // Rounding carry renormalizes; a subnormal rounding to 1.000 becomes exp 1.
    if (rnd_s[SIG_W]) begin
      exp_out_s = exp_n_s + 5'd1;
      man_out_s = 3'b000;
    end else if (rnd_s[SIG_W-1]) begin
      exp_out_s = exp_n_s;
      man_out_s = rnd_s[MAN_W-1:0];
    end else begin
      exp_out_s = 5'd0;
      man_out_s = rnd_s[MAN_W-1:0];
    end
    ovf_s = (exp_out_s > EXP_TOP) ||
            ((exp_out_s == EXP_TOP) && (man_out_s == 3'b111));
    if (s1_nan_q) begin
      y_d = FP8_NAN;
    end else if (s1_sum_q == '0) begin
      y_d = {s1_neg_zero_q, 7'h00};
    end else if (ovf_s) begin
`ifdef FP8_SATURATE_EN
      y_d = {s1_sign_q, FP8_MAXNORM[6:0]};
`else
      y_d = FP8_NAN;
`endif
    end else begin
      y_d = {s1_sign_q, exp_out_s[EXP_W-1:0], man_out_s};
    end
  end

  // Output register; y holds its last value while no result is delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= 8'h00;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q <= y_d;
      end else begin
        y_q <= y_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_float_adder_e4m3.sv
// Directed testbench for float_adder_e4m3 with a real-valued reference model
// for the randomized stream that straddles a reset pulse.
`timescale 1ns/1ps
module tb_float_adder_e4m3;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a        = 8'h00;
  logic [7:0] b        = 8'h00;
  logic       out_valid;
  logic [7:0] y;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic       collect = 1'b0;
  logic [7:0] sa[8];
  logic [7:0] sb[8];

`ifdef FP8_SATURATE_EN
  localparam logic [7:0] OVF_P = 8'h7E;
`else
  localparam logic [7:0] OVF_P = 8'h7F;
`endif

  float_adder_e4m3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Record every delivered result while the stream test is running.
  always @(negedge clk) begin
    if (collect && out_valid) obs_q.push_back(y);
  end

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real mag_of(input logic [6:0] c);
    int m;
    int e;
    m = int'(c[2:0]);
    e = int'(c[6:3]);
    if (e == 0) return real'(m) * pow2(-9);
    return real'(8 + m) * pow2(e - 10);
  endfunction

  // Exact sum in real arithmetic, then nearest representable code, ties to even.
  function automatic logic [7:0] golden(input logic [7:0] xa, input logic [7:0] xb);
    real s, m, err, best_err;
    logic sg;
    logic [6:0] best, c;
    if (xa[6:0] == 7'h7F || xb[6:0] == 7'h7F) return 8'h7F;
    s = (xa[7] ? -1.0 : 1.0) * mag_of(xa[6:0]) + (xb[7] ? -1.0 : 1.0) * mag_of(xb[6:0]);
    if (s == 0.0) return (xa[7] && xb[7]) ? 8'h80 : 8'h00;
    sg = (s < 0.0);
    m  = sg ? -s : s;
    if (m > 464.0) begin
`ifdef FP8_SATURATE_EN
      return {sg, 7'h7E};
`else
      return 8'h7F;
`endif
    end
    best     = 7'h00;
    best_err = m;
    for (int k = 1; k < 127; k++) begin
      c   = 7'(k);
      err = mag_of(c) - m;
      if (err < 0.0) err = -err;
      if (err < best_err || (err == best_err && c[0] == 1'b0)) begin
        best     = c;
        best_err = err;
      end
    end
    return {sg, best};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    cmp_cnt++;
    assert (got === want) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // One isolated pair: out_valid must stay low one edge, then present y.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb,
                       input logic [7:0] want, input string tag);
    @(posedge clk); #1;
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " early_valid"}, {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid"}, {7'b0, out_valid}, 8'h01);
    chk({tag, " y"}, y, want);
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst y", y, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(8'h40, 8'h40, 8'h48, "2+2");
    do_op(8'h28, 8'h10, 8'h29, "0.25+1/32");
    do_op(8'h50, 8'h10, 8'h50, "8+1/32 sticky");
    do_op(8'h40, 8'hC0, 8'h00, "2-2 zero");
    do_op(8'h80, 8'h80, 8'h80, "-0+-0");
    do_op(8'h80, 8'h00, 8'h00, "-0+0");
    do_op(8'h01, 8'h01, 8'h02, "subnorm sum");
    do_op(8'h09, 8'h88, 8'h01, "cancel to subnorm");
    do_op(8'h7E, 8'h7E, OVF_P, "448+448 ovf");
    do_op(8'h7F, 8'h38, 8'h7F, "nan in");
    do_op(8'hFF, 8'h00, 8'h7F, "neg nan in");
    do_op(8'h48, 8'h10, 8'h48, "4+1/32");
    do_op(8'h49, 8'h30, 8'h4A, "4.5+0.5");
    do_op(8'h3F, 8'h18, 8'h40, "tie carry renorm");
    do_op(8'h38, 8'hC0, 8'hB8, "1-2");
    do_op(8'h7E, 8'h58, 8'h7E, "448+16 tie even");
    do_op(8'h7E, 8'h5A, OVF_P, "448+20 round ovf");

    // y holds while no result is delivered.
    @(posedge clk); @(negedge clk);
    chk("hold valid", {7'b0, out_valid}, 8'h00);
    chk("hold y", y, OVF_P);

    // Back-to-back stream with a reset pulse dropping the in-flight pairs.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    obs_q.delete();
    exp_q.delete();
    collect = 1'b1;
    exp_q.push_back(golden(sa[0], sb[0]));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = sa[i]; b = sb[i]; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst out_valid", {7'b0, out_valid}, 8'h00);
    chk("midrst y", y, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 3; i < 8; i++) begin
      exp_q.push_back(golden(sa[i], sb[i]));
      @(posedge clk); #1;
      a = sa[i]; b = sb[i]; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    collect = 1'b0;
    chk("stream count", 8'(obs_q.size()), 8'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) chk($sformatf("stream[%0d]", i), obs_q[i], exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
